// File: rtl/irq_arbiter_n.sv
// rtl/irq_arbiter_n.sv - prioritised external interrupt arbiter with claim/complete handshake
module irq_arbiter_n #(
    parameter int NUM_IRQ     = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_IRQ + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               cfg_we,
    input  logic [ID_W-1:0]    cfg_id,
    input  logic [PRIO_W-1:0]  cfg_prio,
    input  logic               cfg_en,
    input  logic               cfg_edge,
    input  logic [PRIO_W-1:0]  threshold,
    output logic               irq_o,
    input  logic               claim_req,
    output logic [ID_W-1:0]    claim_id,
    output logic               claim_valid,
    input  logic               complete_we,
    input  logic [ID_W-1:0]    complete_id,
    output logic [NUM_IRQ-1:0] pending_o
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] s_d_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] en_q, en_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
    logic [PRIO_W-1:0]  prio_d [NUM_IRQ];
    logic               irq_q;
    logic               claim_valid_q;
    logic [ID_W-1:0]    claim_id_q;

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] set_pend;
    logic [NUM_IRQ-1:0] eligible;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;

    assign s        = sync_q[SYNC_STAGES-1];
    // Level sources stop re-pending while in service; edge sources may queue one more
    assign set_pend = (edge_q & s & ~s_d_q) | (~edge_q & s & ~in_service_q);

    always_comb begin
        eligible = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            eligible[k] = pending_q[k] & en_q[k] & ~in_service_q[k] & (prio_q[k] > threshold);
        end
    end

    // Strict greater-than while scanning upwards keeps ties on the lowest ID
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (eligible[k] && (!win_found || prio_q[k] > win_prio)) begin
                win_found = 1'b1;
                win_id    = ID_W'(k + 1);
                win_prio  = prio_q[k];
            end
        end
    end

    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        en_d         = en_q;
        edge_d       = edge_q;
        prio_d       = prio_q;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (claim_req && win_found && int'(win_id) == k + 1) begin
                pending_d[k]    = set_pend[k] & edge_q[k];
                in_service_d[k] = 1'b1;
            end else if (set_pend[k]) begin
                pending_d[k] = 1'b1;
            end
            if (complete_we && int'(complete_id) == k + 1 && in_service_q[k]) begin
                in_service_d[k] = 1'b0;
            end
            if (cfg_we && int'(cfg_id) == k + 1) begin
                prio_d[k] = cfg_prio;
                en_d[k]   = cfg_en;
                edge_d[k] = cfg_edge;
                if (edge_q[k] && !cfg_edge) begin
                    pending_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int k = 0; k < NUM_IRQ; k++) begin
                prio_q[k] <= '0;
            end
            s_d_q         <= '0;
            pending_q     <= '0;
            in_service_q  <= '0;
            en_q          <= '0;
            edge_q        <= '0;
            irq_q         <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prio_q        <= prio_d;
            s_d_q         <= s;
            pending_q     <= pending_d;
            in_service_q  <= in_service_d;
            en_q          <= en_d;
            edge_q        <= edge_d;
            irq_q         <= |eligible;
            claim_valid_q <= claim_req;
            claim_id_q    <= claim_req ? win_id : '0;
        end
    end

    assign irq_o       = irq_q;
    assign claim_valid = claim_valid_q;
    assign claim_id    = claim_id_q;
    assign pending_o   = pending_q;

endmodule

// File: doc/irq_arbiter_n.md
Name: irq_arbiter_n

Overview:
- Parametrised successor to the fixed 2-source interrupt controller.
- Accepts NUM_IRQ external request lines, which are synchronised into clk.
- Per-source config: edge or level mode, enable, and priority.
- Raises one interrupt line to the control FSM.
- Hands out the winning source through a claim/complete handshake, so the trap handler (via CSR access) can service nested priorities.

Parameters:
NUM_IRQ, 8, number of external sources (1..31); source k is irq_i[k-1], IDs 1..NUM_IRQ, ID 0 = none
PRIO_W, 3, priority field width; priority 0 = never interrupts
SYNC_STAGES, 2, flip-flop stages of input synchroniser (>=2)
ID_W, $clog2(NUM_IRQ+1), width of source ID buses (derived, not overridden)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
irq_i  in  NUM_IRQ  raw external interrupt requests, asynchronous to clk
cfg_we  in  1  config write strobe
cfg_id  in  ID_W  source ID written by cfg_we (0 or >NUM_IRQ ignored)
cfg_prio  in  PRIO_W  priority for cfg_id
cfg_en  in  1  enable for cfg_id
cfg_edge  in  1  1 = rising-edge triggered, 0 = level (active-high)
threshold  in  PRIO_W  only priorities strictly greater than threshold interrupt
irq_o  out  1  interrupt request to ctrl FSM
claim_req  in  1  single-cycle claim strobe
claim_id  out  ID_W  claimed source ID, valid when claim_valid
claim_valid  out  1  one-cycle pulse, cycle after claim_req
complete_we  in  1  completion strobe
complete_id  in  ID_W  source being completed
pending_o  out  NUM_IRQ  pending vector (debug/CSR readback)

Behaviour:
Reset (rst_n low, asynchronous):
- Outputs: irq_o=0, claim_id=0, claim_valid=0, pending_o=0.
- State: all synchroniser stages, pending, in_service, enable, edge and prio cleared.
- Reset mid-claim discards the claim; no claim_valid is issued after release.

Synchroniser and gateway:
- irq_i passes through SYNC_STAGES flops, giving s[k]. One extra flop s_d[k] is kept for edge detection.
- Edge mode: pending[k] sets on s[k] & ~s_d[k].
- Level mode: pending[k] sets while s[k]=1 and in_service[k]=0.
- Set condition is evaluated every cycle regardless of enable. Enable only gates arbitration.
- Edge mode while in_service[k]=1: a new edge still sets pending[k], at most one deep. Further edges are lost.
- Level mode while in_service[k]=1: no new pend.

Arbitration (combinational, every cycle):
- Eligible[k] = pending[k] & en[k] & ~in_service[k] & (prio[k] > threshold).
- Winner is the eligible source with the highest prio. Ties go to the lowest ID.
- irq_o is registered: irq_o(t+1) = |eligible(t). Latency from a synchronised edge to irq_o is 2 clk (pending flop, then irq_o flop). Total from irq_i is SYNC_STAGES+2.

Claim (claim_req at cycle t):
- At t+1: claim_valid=1 and claim_id = winner(t).
- Also at t+1: pending[winner] is cleared and in_service[winner] is set.
- No eligible source at t: claim_id=0 and claim_valid=1, with no state change.
- claim_req on consecutive cycles: each strobe is served independently against the updated state.
- Pending set and claim clear on the same source in the same cycle: set wins (pending stays 1). This applies to edge mode only.

Complete (complete_we):
- Clears in_service[complete_id] at the next edge.
- ID 0, an out-of-range ID, or a source not in service: ignored.
- Level source still asserted after complete: it re-pends the following cycle.
- Claim and complete in the same cycle for the same ID: the claim is evaluated on the pre-complete state, then the complete applies.

Config write:
- Takes effect the next cycle.
- Disabling a source keeps its pending bit. It becomes eligible again when re-enabled.
- Switching a source from edge to level clears its pending bit.

Test Plan:
- Reset, then prio[3]=5, en=1, edge mode, threshold=0; pulse irq_i[2] for 1 cycle -> irq_o=1 exactly SYNC_STAGES+2 cycles later; claim -> claim_id=3, claim_valid pulse, pending_o[2]=0, irq_o=0 the next cycle.
- Sources 2 (prio 3) and 5 (prio 6) both pending -> first claim returns 5; second returns 2; third returns 0 with claim_valid=1.
- Equal prio 4 on IDs 1 and 4, both pending -> claim returns 1; then threshold=4 -> irq_o drops, and claiming returns 0.
- Level source 6 held high: claim -> 6; complete(6) while still high -> pending_o[5]=1 one cycle later and irq_o reasserts; deassert, then claim/complete -> no re-pend.
- Edge source 2 claimed; two more edges while in service -> pending set once; complete -> next claim returns 2, and the claim after that returns 0.
- Assert rst_n low one cycle after claim_req -> claim_valid stays 0; all outputs 0 immediately, asynchronously, without waiting for a clk edge.
